style_word_reader: RTL and testbench

//  Read-side endpoint for the 59-bit computed-style word path. Upstream writer logic

---
 rtl/style_pkg.sv | 6 +
 rtl/style_fifo_mem.sv | 22 ++
 rtl/style_word_reader.sv | 61 ++++++
 tb/tb_style_word_reader.sv | 107 ++++++++++
 4 files changed

// File: rtl/style_pkg.sv
// style_pkg: shared width, word type and default depth for the style word reader
package style_pkg;
   localparam int STYLE_W = 59;
   localparam int DEPTH_DEF = 4;
   typedef logic [STYLE_W-1:0] style_word_t;
endpackage

// File: rtl/style_fifo_mem.sv
// style_fifo_mem: DEPTH x STYLE_W register array, one write port, one async read port
module style_fifo_mem
   import style_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  style_word_t   wdata,
   input  logic [AW-1:0] raddr,
   output style_word_t   rdata
);
   style_word_t mem [DEPTH];
   // storage cleared on reset so the head word reads as zero out of reset
   always_ff @(posedge clock or posedge reset)
      if (reset) mem <= '{default: '0};
      else if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/style_word_reader.sv
// style_word_reader: FIFO buffer delivering style words over valid/ready (optional STYLE_RD_BYPASS_EN)
module style_word_reader
   import style_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ld_en,
   input  style_word_t      wr_data,
   input  logic             flush,
   output logic             rd_valid,
   input  logic             rd_ready,
   output style_word_t      rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             overflow
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic stored_valid, push, pop, byp_take;
   style_word_t head;
   style_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clock(clock),
      .reset(reset),
      .we(push),
      .waddr(wr_ptr),
      .wdata(wr_data),
      .raddr(rd_ptr),
      .rdata(head)
   );
   assign stored_valid = count != '0;
   assign full = count == CNT_W'(DEPTH);
`ifdef STYLE_RD_BYPASS_EN
   logic byp;
   assign byp = ~stored_valid & ld_en & ~flush;
   assign byp_take = byp & rd_ready;
   assign rd_valid = stored_valid | byp;
   assign rd_data = byp ? wr_data : head;
`else
   assign byp_take = 1'b0;
   assign rd_valid = stored_valid;
   assign rd_data = head;
`endif
   assign pop = stored_valid & rd_ready & ~flush;
   assign push = ld_en & (~full | pop) & ~flush & ~byp_take;
   // pointer, occupancy and sticky overflow tracking; flush clears everything but storage
   always_ff @(posedge clock or posedge reset)
      if (reset | flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + CNT_W'(push) - CNT_W'(pop);
         overflow <= overflow | (ld_en & ~push & ~byp_take);
      end
endmodule

// File: tb/tb_style_word_reader.sv
// tb_style_word_reader: directed and random checks of style_word_reader against a queue model
module tb_style_word_reader;
   import style_pkg::*;
   localparam int DEPTH = 4;
   logic clock = 0, reset = 1, ld_en = 0, flush = 0, rd_ready = 0;
   style_word_t wr_data = '0, rd_data;
   logic rd_valid, full, overflow;
   logic [2:0] count;
   int checks = 0, errors = 0;
   style_word_t q[$];
   bit m_ovf = 0;

   style_word_reader #(.DEPTH(DEPTH), .CNT_W(3)) dut (
      .clock(clock), .reset(reset), .ld_en(ld_en), .wr_data(wr_data), .flush(flush),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
      .full(full), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      bit ev;
      style_word_t ed;
      ev = q.size() != 0;
      ed = ev ? q[0] : '0;
`ifdef STYLE_RD_BYPASS_EN
      if (!ev && ld_en && !flush) begin ev = 1; ed = wr_data; end
`endif
      chk({tag, ".valid"}, 64'(rd_valid), 64'(ev));
      if (ev) chk({tag, ".data"}, 64'(rd_data), 64'(ed));
      chk({tag, ".count"}, 64'(count), 64'(q.size()));
      chk({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
      chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
   endtask

   task automatic step(input string tag, input bit ld, input style_word_t d, input bit fl, input bit rdy);
      bit popped;
      int sz;
      @(negedge clock);
      ld_en = ld; wr_data = d; flush = fl; rd_ready = rdy;
      #1 check_outputs(tag);
      sz = q.size();
      if (fl) begin
         q.delete();
         m_ovf = 0;
      end else begin
         popped = sz != 0 && rdy;
         if (popped) void'(q.pop_front());
`ifdef STYLE_RD_BYPASS_EN
         if (sz == 0 && ld && rdy) ld = 0;
`endif
         if (ld) begin
            if (sz < DEPTH || popped) q.push_back(d);
            else m_ovf = 1;
         end
      end
      @(posedge clock);
   endtask

   initial begin
      #1 check_outputs("reset");
      chk("reset.rd_data", 64'(rd_data), 64'h0);
      @(negedge clock) reset = 0;
      step("single", 1, 59'h0123456789ABCDE, 0, 1);
      step("single_rd", 0, '0, 0, 1);
      step("single_empty", 0, '0, 0, 1);
      for (int i = 1; i <= 4; i++) step("fill", 1, style_word_t'(i), 0, 0);
      step("drop5", 1, style_word_t'(5), 0, 0);
      for (int i = 0; i < 5; i++) step("drain", 0, '0, 0, 1);
      step("clr", 0, '0, 1, 0);
      for (int i = 1; i <= 4; i++) step("fill2", 1, style_word_t'(i), 0, 0);
      step("full_pp", 1, style_word_t'(5), 0, 1);
      for (int i = 0; i < 5; i++) step("drain2", 0, '0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         step("wrap_w", 1, style_word_t'(32'h100 + i), 0, 0);
         step("wrap_r", 0, '0, 0, 1);
      end
      for (int i = 0; i < 5; i++) step("ovf_fill", 1, style_word_t'(32'h200 + i), 0, 0);
      step("flush_ld", 1, style_word_t'(32'hDEAD), 1, 0);
      step("post_flush", 0, '0, 0, 0);
      step("post_flush2", 0, '0, 0, 1);
      step("pre_rst", 1, style_word_t'(32'h300), 0, 0);
      step("pre_rst", 1, style_word_t'(32'h301), 0, 0);
      step("pre_rst", 0, '0, 0, 0);
      #2 reset = 1;
      q.delete();
      m_ovf = 0;
      ld_en = 0;
      #1 check_outputs("async_rst");
      chk("async_rst.rd_data", 64'(rd_data), 64'h0);
      #1 reset = 0;
      for (int i = 0; i < 300; i++)
         step("rand", ($urandom_range(0, 99) < 60), style_word_t'({$urandom(), $urandom()}),
              ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 45));
      step("final", 0, '0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
